// File: rtl/multi_interval_timer.sv
// Multi-channel Avalon-MM interval timer: NUM_CH down-counters sharing one prescaler,
// with per-channel timeout/missed flags and a combined, registered level interrupt.
module multi_interval_timer #(
  parameter int          NUM_CH       = 4,
  parameter int          CNT_W        = 32,
  parameter int          PRE_W        = 8,
  parameter int          ADDR_W       = 5,
  parameter logic [31:0] RESET_PERIOD = 32'h15F8F
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              chipselect,
  input  logic [ADDR_W-1:0] address,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq
);
  localparam logic [ADDR_W-1:0] A_IRQ_PEND = ADDR_W'(4 * NUM_CH);
  localparam logic [ADDR_W-1:0] A_PRESCALE = ADDR_W'(4 * NUM_CH + 1);
  localparam logic [CNT_W-1:0]  RST_CNT    = RESET_PERIOD[CNT_W-1:0];

  logic [CNT_W-1:0]  r_cnt    [NUM_CH];
  logic [CNT_W-1:0]  r_period [NUM_CH];
  logic [CNT_W-1:0]  r_snap   [NUM_CH];
  logic [4:0]        r_ctrl   [NUM_CH];
  logic [NUM_CH-1:0] r_to, r_missed, r_run, r_nz, r_force;
  logic [PRE_W-1:0]  r_pre, r_prescale;
  logic              r_pre_ld;
  logic [31:0]       r_rdata;
  logic              r_irq;

  logic              w_wr, w_tick, w_wr_pre;
  logic [NUM_CH-1:0] w_wr_stat, w_wr_ctrl, w_wr_per, w_wr_snap;
  logic [NUM_CH-1:0] w_start, w_stop, w_en, w_cnt_zero, w_evt, w_chirq;
  logic [31:0]       w_rdata;

  assign w_wr     = chipselect & ~write_n;
  assign w_wr_pre = w_wr && (address == A_PRESCALE);
  assign w_tick   = (r_pre == '0);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
    w_wr_stat  = '0;
    w_wr_ctrl  = '0;
    w_wr_per   = '0;
    w_wr_snap  = '0;
    w_start    = '0;
    w_stop     = '0;
    w_en       = '0;
    w_cnt_zero = '0;
    w_evt      = '0;
    w_chirq    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_wr_stat[c]  = w_wr && (address == ADDR_W'(4 * c));
      w_wr_ctrl[c]  = w_wr && (address == ADDR_W'(4 * c + 1));
      w_wr_per[c]   = w_wr && (address == ADDR_W'(4 * c + 2));
      w_wr_snap[c]  = w_wr && (address == ADDR_W'(4 * c + 3));
      // START wins over STOP when both are set in one write
      w_start[c]    = w_wr_ctrl[c] & writedata[2];
      w_stop[c]     = w_wr_ctrl[c] & writedata[3] & ~writedata[2];
      w_en[c]       = r_run[c] & (~r_ctrl[c][4] | w_tick);
      w_cnt_zero[c] = (r_cnt[c] == '0);
      w_evt[c]      = w_cnt_zero[c] & r_nz[c];
      w_chirq[c]    = r_to[c] & r_ctrl[c][0];
    end
  end

  always_comb begin
    w_rdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (address == ADDR_W'(4 * c))     w_rdata = {29'd0, r_missed[c], r_run[c], r_to[c]};
      if (address == ADDR_W'(4 * c + 1)) w_rdata = 32'(r_ctrl[c]);
      if (address == ADDR_W'(4 * c + 2)) w_rdata = 32'(r_period[c]);
      if (address == ADDR_W'(4 * c + 3)) w_rdata = 32'(r_snap[c]);
    end
    if (address == A_IRQ_PEND) w_rdata = 32'(w_chirq);
    if (address == A_PRESCALE) w_rdata = 32'(r_prescale);
  end

  // Shared prescaler: a PRESCALE write restarts the count one cycle later from the new value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      r_pre      <= '0;
      r_prescale <= '0;
      r_pre_ld   <= 1'b0;
    end else begin
      r_pre_ld <= w_wr_pre;
      if (w_wr_pre) r_prescale <= writedata[PRE_W-1:0];
      if (r_pre_ld || w_tick) r_pre <= r_prescale;
      else                    r_pre <= r_pre - PRE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: these arrays are a handful of flops, not RAM, so resetting them costs nothing and is required.
      for (int c = 0; c < NUM_CH; c++) begin
        r_cnt[c]    <= RST_CNT;
        r_period[c] <= RST_CNT;
        r_snap[c]   <= '0;
        r_ctrl[c]   <= '0;
      end
      r_to     <= '0;
      r_missed <= '0;
      r_run    <= '0;
      r_nz     <= '0;
      r_force  <= '0;
    end else begin
      r_force <= w_wr_per;
      r_nz    <= ~w_cnt_zero;
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_wr_per[c])  r_period[c] <= writedata[CNT_W-1:0];
        if (w_wr_ctrl[c]) r_ctrl[c]   <= writedata[4:0];
        if (w_wr_snap[c]) r_snap[c]   <= r_cnt[c];

        // One-shot channels park at 0; a later START reloads from PERIOD.
        if (r_force[c] || (w_start[c] && w_cnt_zero[c])) r_cnt[c] <= r_period[c];
        else if (w_en[c] && !w_cnt_zero[c])              r_cnt[c] <= r_cnt[c] - CNT_W'(1);
        else if (w_en[c] && r_ctrl[c][1])                r_cnt[c] <= r_period[c];

        if (w_start[c]) r_run[c] <= 1'b1;
        else if (w_stop[c] || r_force[c] || (w_en[c] && w_cnt_zero[c] && !r_ctrl[c][1]))
          r_run[c] <= 1'b0;

        // A timeout coinciding with a clearing STATUS write is kept; MISSED stays clear.
        if (w_evt[c])          r_to[c] <= 1'b1;
        else if (w_wr_stat[c]) r_to[c] <= 1'b0;
        if (w_wr_stat[c])              r_missed[c] <= 1'b0;
        else if (w_evt[c] && r_to[c])  r_missed[c] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_rdata <= w_rdata;
      r_irq   <= |w_chirq;
    end
  end

  assign readdata = r_rdata;
  assign irq      = r_irq;
endmodule

// File: tb/tb_multi_interval_timer.sv
// Directed bench for multi_interval_timer: register reads go through a queue-based
// scoreboard checked by a separate monitor; irq and async-reset behaviour are checked directly.
module tb_multi_interval_timer;
  localparam int          ADDR_W = 5;
  localparam logic [31:0] RST_P  = 32'h15F8F;

  logic              clk        = 1'b0;
  logic              reset_n    = 1'b0;
  logic              chipselect = 1'b0;
  logic              write_n    = 1'b1;
  logic [ADDR_W-1:0] address    = '0;
  logic [31:0]       writedata  = '0;
  logic [31:0]       readdata;
  logic              irq;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic        rd_req = 1'b0;
  logic        rd_vld = 1'b0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  multi_interval_timer #(
    .NUM_CH(4), .CNT_W(32), .PRE_W(8), .ADDR_W(ADDR_W), .RESET_PERIOD(RST_P)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .chipselect(chipselect),
    .address   (address),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Read data appears one cycle after the address is presented.
  always @(posedge clk) rd_vld <= rd_req;

  always @(negedge clk) begin : monitor
    string       nm;
    logic [31:0] e;
    if (rd_vld) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_underflow: got 0x%08h with no expectation queued", readdata);
      end else begin
        nm = name_q.pop_front();
        e  = exp_q.pop_front();
        check(nm, readdata, e);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, input logic [31:0] e, input string nm);
    address = a;
    rd_req  = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    rd_req = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    // Reset and reset values
    repeat (3) @(posedge clk);
    #1;
    check("irq_in_reset", {31'd0, irq}, 32'd0);
    check("rdata_in_reset", readdata, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    rd(5'd2,  RST_P, "ch0_period_reset");
    rd(5'd0,  32'd0, "ch0_status_reset");
    rd(5'd18, 32'd0, "unmapped_18");
    check("irq_after_reset", {31'd0, irq}, 32'd0);

    // ch1 continuous, period 9 -> timeout every 10 cycles
    wr(5'd6, 32'd9);
    wr(5'd5, 32'h7);
    idle(9);
    check("ch1_irq_before_to", {31'd0, irq}, 32'd0);
    rd(5'd4, 32'h2, "ch1_status_pre_evt1");
    check("ch1_irq_same_cycle_as_to", {31'd0, irq}, 32'd0);
    rd(5'd4, 32'h3, "ch1_status_evt1");
    check("ch1_irq_one_after_to", {31'd0, irq}, 32'd1);
    rd(5'd16, 32'h2, "irq_pend_ch1");
    wr(5'd4, 32'd0);
    idle(6);
    rd(5'd4, 32'h2, "ch1_status_pre_evt2");
    rd(5'd4, 32'h3, "ch1_status_evt2");
    wr(5'd5, 32'h8);
    wr(5'd4, 32'd0);

    // ch0 one-shot, period 3
    wr(5'd2, 32'd3);
    wr(5'd1, 32'h5);
    idle(3);
    rd(5'd0, 32'h2, "ch0_status_pre_evt");
    rd(5'd0, 32'h1, "ch0_status_evt_run_off");
    wr(5'd3, 32'd0);
    rd(5'd3, 32'd0, "ch0_snap_holds_zero");
    check("ch0_irq", {31'd0, irq}, 32'd1);
    wr(5'd0, 32'd0);
    idle(3);
    rd(5'd0, 32'd0, "ch0_no_second_evt");
    wr(5'd1, 32'h5);
    idle(3);
    rd(5'd0, 32'h2, "ch0_restart_pre_evt");
    rd(5'd0, 32'h1, "ch0_restart_evt");
    wr(5'd1, 32'd0);
    wr(5'd0, 32'd0);

    // Prescaler 4, ch2 period 2 with PSE -> 15-cycle spacing; second event sets MISSED
    wr(5'd17, 32'd4);
    wr(5'd10, 32'd2);
    wr(5'd9,  32'h16);
    idle(9);
    rd(5'd8, 32'h2, "ch2_status_pre_evt1");
    rd(5'd8, 32'h3, "ch2_status_evt1");
    idle(13);
    rd(5'd8, 32'h3, "ch2_status_pre_evt2");
    rd(5'd8, 32'h7, "ch2_status_missed");
    wr(5'd8, 32'd0);
    rd(5'd8, 32'h2, "ch2_status_cleared");
    rd(5'd17, 32'd4, "prescale_readback");
    wr(5'd9,  32'h8);
    wr(5'd17, 32'd0);

    // ch3: clearing write lands on the timeout cycle; then PERIOD write mid-count
    wr(5'd14, 32'd4);
    wr(5'd13, 32'h7);
    idle(9);
    wr(5'd12, 32'd0);
    rd(5'd12, 32'h3, "ch3_event_beats_clear");
    check("ch3_irq", {31'd0, irq}, 32'd1);
    wr(5'd14, 32'h55);
    idle(1);
    rd(5'd12, 32'h1, "ch3_period_write_stops");
    wr(5'd15, 32'd0);
    rd(5'd15, 32'h55, "ch3_snap_new_period");
    rd(5'd14, 32'h55, "ch3_period_readback");

    // Asynchronous reset mid-count with irq high
    wr(5'd1, 32'h6);
    address = 5'd14;
    idle(2);
    check("pre_reset_rdata", readdata, 32'h55);
    check("pre_reset_irq", {31'd0, irq}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_irq", {31'd0, irq}, 32'd0);
    check("async_reset_rdata", readdata, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) begin
      wr(ADDR_W'(4 * c + 3), 32'd0);
      rd(ADDR_W'(4 * c + 3), RST_P, $sformatf("ch%0d_snap_after_reset", c));
    end
    rd(5'd0,  32'd0, "ch0_status_after_reset");
    rd(5'd16, 32'd0, "irq_pend_after_reset");
    check("irq_after_reset2", {31'd0, irq}, 32'd0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) idle(1);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: %0d reads never completed", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
